// File: rtl/ddr_pkg.sv
// ddr_pkg: shared command/state encodings, error codes, timing limits and mode decode for the DDR command responder
package ddr_pkg;
  localparam int T_RP  = 3;
  localparam int T_MRD = 2;
  localparam int T_RFC = 11;
  localparam int T_RCD = 3;
  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;
  typedef enum logic [3:0] {
    S_WAIT_CKE, S_PRE1, S_EMR, S_MR1, S_PRE2, S_REF1, S_REF2, S_MR2, S_READY
  } init_e;
  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_PRE_INIT = 3'd1;
  localparam logic [2:0] E_SEQ      = 3'd2;
  localparam logic [2:0] E_TIMING   = 3'd3;
  localparam logic [2:0] E_CLOSED   = 3'd4;
  localparam logic [2:0] E_REOPEN   = 3'd5;
  localparam logic [2:0] E_MODE     = 3'd6;
  typedef struct packed {
    logic       v;
    logic [1:0] ba;
    logic [9:0] col;
  } rd_ent_t;
  function automatic logic [1:0] cl_dec(input logic [2:0] c);
    return c == 3'b010 ? 2'd2 : c == 3'b011 ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [3:0] bl_dec(input logic [2:0] c);
    return c == 3'b001 ? 4'd2 : c == 3'b010 ? 4'd4 : c == 3'b011 ? 4'd8 : 4'd0;
  endfunction
  function automatic logic [15:0] beat(input logic [1:0] ba, input logic [9:0] col);
    return {ba, 4'b0000, col};
  endfunction
endpackage

// File: rtl/ddr_bank_tracker.sv
// ddr_bank_tracker: per-bank open flags and ACTIVE->READ/WRITE (T_RCD) holdoff counters
//  ports: clk133/rst_n clock and async active-low reset; act/pre/pre_all/ba accepted bank commands;
//         open_mask bank-open flags; rcd_busy banks still inside T_RCD.
//  DDR_RESP_CHECK_EN: when undefined the T_RCD counters are absent and rcd_busy is tied low.
module ddr_bank_tracker
  import ddr_pkg::*;
(
  input  logic       clk133,
  input  logic       rst_n,
  input  logic       act,
  input  logic       pre,
  input  logic       pre_all,
  input  logic [1:0] ba,
  output logic [3:0] open_mask,
  output logic [3:0] rcd_busy
);
  always_ff @(posedge clk133 or negedge rst_n)
    if (!rst_n) open_mask <= '0;
    else if (act) open_mask[ba] <= 1'b1;
    else if (pre) open_mask <= pre_all ? 4'b0000 : open_mask & ~(4'b0001 << ba);
`ifdef DDR_RESP_CHECK_EN
  logic [1:0] rcd [4];
  always_ff @(posedge clk133 or negedge rst_n)
    if (!rst_n) rcd <= '{default: '0};
    else for (int i = 0; i < 4; i++) rcd[i] <= act && ba == 2'(i) ? 2'(T_RCD - 1) : rcd[i] != 2'd0 ? rcd[i] - 2'd1 : rcd[i];
  assign rcd_busy = {rcd[3] != 2'd0, rcd[2] != 2'd0, rcd[1] != 2'd0, rcd[0] != 2'd0};
`else
  assign rcd_busy = 4'b0000;
`endif
endmodule

// File: rtl/ddr_cmd_responder.sv
// ddr_cmd_responder: memory-side DDR command decoder with init tracking, mode registers, bank checks and patterned read data
//  ports: clk133, rst_n (async active-low); sd_CKE/CS/RAS/CAS/WE/BA/A controller command bus;
//         rd_data/rd_valid read beat pairs; init_done; mode_cl/mode_bl latched mode; err/err_code first error.
//  DDR_RESP_CHECK_EN: defined -> T_RP/T_MRD/T_RFC/T_RCD enforced (err_code 3); undefined -> no timing checks.
module ddr_cmd_responder
  import ddr_pkg::*;
(
  input  logic        clk133,
  input  logic        rst_n,
  input  logic        sd_CKE,
  input  logic        sd_CS,
  input  logic        sd_RAS,
  input  logic        sd_CAS,
  input  logic        sd_WE,
  input  logic [1:0]  sd_BA,
  input  logic [12:0] sd_A,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        init_done,
  output logic [1:0]  mode_cl,
  output logic [3:0]  mode_bl,
  output logic        err,
  output logic [2:0]  err_code
);
  cmd_e       cmd;
  init_e      st, nxt;
  logic       nop, lmr0, pre_all, bank_open, seq_ok, t_busy;
  logic       act_ok, pre_ok, rd_ok, wr_ok, mode_ld;
  logic [2:0] e;
  logic [1:0] cl_new;
  logic [3:0] bl_new, open_mask, rcd_busy;
  rd_ent_t    pipe [3];
  rd_ent_t    ent;
  logic [1:0] b_ba;
  logic [9:0] b_col;
  logic [2:0] b_left;
  assign cmd       = sd_CS ? CMD_NOP : cmd_e'({sd_RAS, sd_CAS, sd_WE});
  assign nop       = cmd == CMD_NOP;
  assign lmr0      = cmd == CMD_LMR && sd_BA == 2'd0;
  assign pre_all   = cmd == CMD_PRE && sd_A[10];
  assign bank_open = open_mask[sd_BA];
  assign cl_new    = cl_dec(sd_A[6:4]);
  assign bl_new    = bl_dec(sd_A[2:0]);
  assign ent       = '{v: 1'b1, ba: sd_BA, col: sd_A[9:0]};
  assign seq_ok = (st == S_PRE1 || st == S_PRE2) ? pre_all :
                  st == S_EMR ? cmd == CMD_LMR && sd_BA == 2'd1 && sd_A == 13'd0 :
                  (st == S_MR1 || st == S_MR2) ? lmr0 :
                  (st == S_REF1 || st == S_REF2) ? cmd == CMD_REF : 1'b0;
  always_comb begin
    e = E_NONE;
    nxt = st;
    act_ok = 1'b0;
    pre_ok = 1'b0;
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    mode_ld = 1'b0;
    if (!nop && !sd_CKE) e = E_PRE_INIT;
    else if (st == S_WAIT_CKE) begin
      nxt = sd_CKE ? S_PRE1 : S_WAIT_CKE;
      e = nop ? E_NONE : E_SEQ;
    end else if (!nop && st != S_READY) begin
      nxt = seq_ok ? init_e'(st + 4'd1) : st;
      e = seq_ok ? E_NONE : E_SEQ;
      mode_ld = seq_ok && lmr0;
    end else if (!nop) begin
      act_ok = cmd == CMD_ACT && !bank_open;
      pre_ok = cmd == CMD_PRE;
      rd_ok = cmd == CMD_RD && bank_open;
      wr_ok = cmd == CMD_WR && bank_open;
      mode_ld = lmr0;
      e = cmd == CMD_ACT && bank_open ? E_REOPEN :
          (cmd == CMD_RD || cmd == CMD_WR) && !bank_open ? E_CLOSED :
          (cmd == CMD_RD || cmd == CMD_WR) && rcd_busy[sd_BA] ? E_TIMING : E_NONE;
    end
    if (mode_ld && (cl_new == 2'd0 || bl_new == 4'd0) && e == E_NONE) e = E_MODE;
    if (!nop && sd_CKE && t_busy && e == E_NONE) e = E_TIMING;
  end
  ddr_bank_tracker u_banks (
    .clk133   (clk133),
    .rst_n    (rst_n),
    .act      (act_ok),
    .pre      (pre_ok),
    .pre_all  (sd_A[10]),
    .ba       (sd_BA),
    .open_mask(open_mask),
    .rcd_busy (rcd_busy)
  );
`ifdef DDR_RESP_CHECK_EN
  logic [3:0] tmr, tdec;
  assign tdec = tmr != 4'd0 ? tmr - 4'd1 : tmr;
  always_ff @(posedge clk133 or negedge rst_n)
    if (!rst_n) tmr <= '0;
    else tmr <= nop || !sd_CKE ? tdec : cmd == CMD_PRE ? 4'(T_RP - 1) :
                cmd == CMD_LMR ? 4'(T_MRD - 1) : cmd == CMD_REF ? 4'(T_RFC - 1) : tdec;
  assign t_busy = tmr != 4'd0;
`else
  assign t_busy = 1'b0;
`endif
  // Reads enter the latency pipe at slot CL-1 and launch from slot 0, so a newer read
  // launching later overrides whatever burst is still running.
  always_ff @(posedge clk133 or negedge rst_n)
    if (!rst_n) begin
      st <= S_WAIT_CKE;
      init_done <= 1'b0;
      mode_cl <= '0;
      mode_bl <= '0;
      err <= 1'b0;
      err_code <= '0;
      pipe <= '{default: '0};
      rd_valid <= 1'b0;
      rd_data <= '0;
      b_ba <= '0;
      b_col <= '0;
      b_left <= '0;
    end else begin
      st <= nxt;
      if (nxt == S_READY) init_done <= 1'b1;
      if (!err && e != E_NONE) begin
        err <= 1'b1;
        err_code <= e;
      end
      if (mode_ld && cl_new != 2'd0) mode_cl <= cl_new;
      if (mode_ld && bl_new != 4'd0) mode_bl <= bl_new;
      pipe[0] <= pipe[1];
      pipe[1] <= pipe[2];
      pipe[2] <= '0;
      if (rd_ok && mode_cl == 2'd3) pipe[2] <= ent;
      else if (rd_ok) pipe[1] <= ent;
      if (pipe[0].v) begin
        rd_valid <= 1'b1;
        rd_data <= {beat(pipe[0].ba, pipe[0].col), beat(pipe[0].ba, pipe[0].col + 10'd1)};
        b_ba <= pipe[0].ba;
        b_col <= pipe[0].col + 10'd2;
        b_left <= mode_bl[3:1] - 3'd1;
      end else if (b_left != 3'd0) begin
        rd_valid <= 1'b1;
        rd_data <= {beat(b_ba, b_col), beat(b_ba, b_col + 10'd1)};
        b_col <= b_col + 10'd2;
        b_left <= b_left - 3'd1;
      end else rd_valid <= 1'b0;
      if (wr_ok) begin
        pipe <= '{default: '0};
        rd_valid <= 1'b0;
        b_left <= '0;
      end
    end
endmodule

// File: tb/tb_ddr_cmd_responder.sv
// tb_ddr_cmd_responder: directed scoreboard bench for ddr_cmd_responder
module tb_ddr_cmd_responder;
  logic        clk133 = 1'b0, rst_n = 1'b0, sd_CKE = 1'b0, sd_CS = 1'b1;
  logic        sd_RAS = 1'b1, sd_CAS = 1'b1, sd_WE = 1'b1;
  logic [1:0]  sd_BA = 2'd0;
  logic [12:0] sd_A = 13'd0;
  logic [31:0] rd_data;
  logic        rd_valid, init_done, err;
  logic [1:0]  mode_cl;
  logic [3:0]  mode_bl;
  logic [2:0]  err_code;
  typedef struct {
    int          cyc;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, passed = 0;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;
  ddr_cmd_responder dut (
    .clk133(clk133), .rst_n(rst_n), .sd_CKE(sd_CKE), .sd_CS(sd_CS), .sd_RAS(sd_RAS),
    .sd_CAS(sd_CAS), .sd_WE(sd_WE), .sd_BA(sd_BA), .sd_A(sd_A), .rd_data(rd_data),
    .rd_valid(rd_valid), .init_done(init_done), .mode_cl(mode_cl), .mode_bl(mode_bl),
    .err(err), .err_code(err_code)
  );
  always #4 clk133 = ~clk133;
  always @(posedge clk133) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask
  always @(negedge clk133) begin : mon
    exp_t x;
    if (rst_n && rd_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL rd_unexpected: rd_valid=1 data 0x%0h at cycle %0d, expected no beat", rd_data, cyc);
      end else begin
        x = q.pop_front();
        chk("rd_cycle", 32'(cyc), 32'(x.cyc));
        chk("rd_data", rd_data, x.d);
      end
    end
  end
  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a);
    sd_CS = 1'b0;
    {sd_RAS, sd_CAS, sd_WE} = c;
    sd_BA = ba;
    sd_A = a;
    @(negedge clk133);
  endtask
  task automatic nop(input int n);
    repeat (n) issue(C_NOP, 2'd0, 13'd0);
  endtask
  task automatic expect_rd(input int at, input logic [31:0] d);
    q.push_back('{at, d});
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_mode_cl"}, 32'(mode_cl), 32'd0);
    chk({tag, "_mode_bl"}, 32'(mode_bl), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    sd_CKE = 1'b0;
    sd_CS = 1'b1;
    repeat (2) @(negedge clk133);
    rst_n = 1'b1;
    @(negedge clk133);
  endtask
  task automatic do_init(input logic [12:0] mr2);
    sd_CKE = 1'b0;
    nop(5);
    sd_CKE = 1'b1;
    nop(1);
    issue(C_PRE, 2'd0, 13'h400);
    nop(2);
    issue(C_LMR, 2'd1, 13'h000);
    nop(1);
    issue(C_LMR, 2'd0, 13'h021);
    nop(1);
    issue(C_PRE, 2'd0, 13'h400);
    nop(2);
    issue(C_REF, 2'd0, 13'd0);
    nop(10);
    issue(C_REF, 2'd0, 13'd0);
    nop(10);
    issue(C_LMR, 2'd0, mr2);
  endtask
  initial begin
    int t;
    repeat (2) @(negedge clk133);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk133);
    do_init(13'h021);
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_cl", 32'(mode_cl), 32'd2);
    chk("init_bl", 32'(mode_bl), 32'd2);
    chk("init_err", 32'(err), 32'd0);
    nop(1);
    issue(C_LMR, 2'd0, 13'h032);
    nop(1);
    chk("lmr_cl3", 32'(mode_cl), 32'd3);
    chk("lmr_bl4", 32'(mode_bl), 32'd4);
    issue(C_ACT, 2'd1, 13'd5);
    nop(2);
    issue(C_RD, 2'd1, 13'h010);
    expect_rd(cyc + 3, 32'h40104011);
    expect_rd(cyc + 4, 32'h40124013);
    nop(6);
    issue(C_LMR, 2'd0, 13'h033);
    nop(1);
    chk("lmr_bl8", 32'(mode_bl), 32'd8);
    issue(C_RD, 2'd1, 13'h020);
    expect_rd(cyc + 3, 32'h40204021);
    issue(C_RD, 2'd1, 13'h040);
    t = cyc;
    expect_rd(t + 3, 32'h40404041);
    expect_rd(t + 4, 32'h40424043);
    expect_rd(t + 5, 32'h40444045);
    expect_rd(t + 6, 32'h40464047);
    nop(8);
    issue(C_RD, 2'd1, 13'h080);
    nop(1);
    issue(C_WR, 2'd1, 13'h000);
    nop(6);
    chk("read_err", 32'(err), 32'd0);
    chk("read_queue_drained", 32'(q.size()), 32'd0);
    do_reset();
    do_init(13'h021);
    chk("closed_pre_err", 32'(err), 32'd0);
    nop(1);
    issue(C_RD, 2'd2, 13'h000);
    chk("closed_err", 32'(err), 32'd1);
    chk("closed_code", 32'(err_code), 32'd4);
    nop(5);
    do_reset();
    do_init(13'h021);
    nop(1);
    issue(C_REF, 2'd0, 13'd0);
    nop(4);
    issue(C_ACT, 2'd0, 13'd0);
`ifdef DDR_RESP_CHECK_EN
    chk("trfc_err", 32'(err), 32'd1);
    chk("trfc_code", 32'(err_code), 32'd3);
`else
    chk("trfc_err", 32'(err), 32'd0);
    chk("trfc_code", 32'(err_code), 32'd0);
`endif
    do_reset();
    do_init(13'h021);
    nop(1);
    issue(C_ACT, 2'd0, 13'd1);
    nop(2);
    issue(C_ACT, 2'd0, 13'd2);
    chk("reopen_code", 32'(err_code), 32'd5);
    do_reset();
    do_init(13'h041);
    chk("mode_init_done", 32'(init_done), 32'd1);
    chk("mode_code", 32'(err_code), 32'd6);
    chk("mode_cl_kept", 32'(mode_cl), 32'd2);
    chk("mode_bl_new", 32'(mode_bl), 32'd2);
    do_reset();
    sd_CKE = 1'b0;
    issue(C_ACT, 2'd0, 13'd0);
    chk("cke_low_code", 32'(err_code), 32'd1);
    do_reset();
    sd_CKE = 1'b0;
    nop(5);
    sd_CKE = 1'b1;
    nop(1);
    issue(C_LMR, 2'd0, 13'h021);
    chk("seq_err", 32'(err), 32'd1);
    chk("seq_code", 32'(err_code), 32'd2);
    rst_n = 1'b0;
    #1;
    check_zero("rst_pulse");
    @(negedge clk133);
    rst_n = 1'b1;
    do_init(13'h021);
    chk("reinit_done", 32'(init_done), 32'd1);
    chk("reinit_err", 32'(err), 32'd0);
    nop(4);
    chk("rd_queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
